// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall and branch-mispredict flush control for an in-order pipeline.
//
// Ports:
//   CLK, RST            clock (rising edge) and asynchronous active-high reset
//   MEMREAD_ID_EX       ID/EX instruction is a load
//   ARD_ID_EX           ID/EX destination register
//   ARS1_IF_ID/ARS2_IF_ID  IF/ID source registers; USES_RS2_IF_ID qualifies rs2
//   BEQ_WRONG_PRED      branch resolved as mispredicted this cycle
//   STALL, MUX_SEL, PCWRITE, PC_REDIRECT, FLUSH  pipeline control outputs
//   STALL_CNT, FLUSH_CNT  saturating performance counters (only with HAZARD_PERF_CNT_EN)
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the performance counters.
// Legal ranges: LOAD_LAT 1..7, FLUSH_CYC 1..3.
module hazard_ctrl_unit #(
    parameter int unsigned AW        = 5,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          MEMREAD_ID_EX,
    input  logic [AW-1:0] ARD_ID_EX,
    input  logic [AW-1:0] ARS1_IF_ID,
    input  logic [AW-1:0] ARS2_IF_ID,
    input  logic          USES_RS2_IF_ID,
    input  logic          BEQ_WRONG_PRED,
    output logic          STALL,
    output logic          MUX_SEL,
    output logic          PCWRITE,
    output logic          PC_REDIRECT,
`ifdef HAZARD_PERF_CNT_EN
    output logic          FLUSH,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
`else
    output logic          FLUSH
`endif
);

    typedef enum logic [1:0] {StRun, StLdStall, StFlush} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hz;

    // Register 0 is hardwired zero, so it never creates a dependency.
    assign hz = MEMREAD_ID_EX && (ARD_ID_EX != '0) &&
                ((ARD_ID_EX == ARS1_IF_ID) || (USES_RS2_IF_ID && (ARD_ID_EX == ARS2_IF_ID)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (BEQ_WRONG_PRED) begin
            // Mispredict wins over everything, including an in-flight load stall.
            if (FLUSH_CYC > 1) begin
                state_d = StFlush;
                cnt_d   = 3'(FLUSH_CYC - 1);
            end else begin
                state_d = StRun;
                cnt_d   = 3'd0;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hz && (LOAD_LAT > 1)) begin
                        state_d = StLdStall;
                        cnt_d   = 3'(LOAD_LAT - 1);
                    end
                end
                StLdStall, StFlush: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        STALL       = 1'b0;
        MUX_SEL     = 1'b0;
        PCWRITE     = 1'b1;
        PC_REDIRECT = 1'b0;
        FLUSH       = 1'b0;
        if (!RST) begin
            if (BEQ_WRONG_PRED) begin
                FLUSH       = 1'b1;
                PC_REDIRECT = 1'b1;
                MUX_SEL     = 1'b1;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (hz) begin
                            STALL   = 1'b1;
                            MUX_SEL = 1'b1;
                            PCWRITE = 1'b0;
                        end
                    end
                    StLdStall: begin
                        STALL   = 1'b1;
                        MUX_SEL = 1'b1;
                        PCWRITE = 1'b0;
                    end
                    StFlush: begin
                        FLUSH   = 1'b1;
                        MUX_SEL = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturate at all-ones rather than wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (STALL && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + 1'b1;
            if (FLUSH && (FLUSH_CNT != '1)) FLUSH_CNT <= FLUSH_CNT + 1'b1;
        end
    end
`endif

endmodule
